// File: rtl/lsu_bus_master.sv
// MEM-stage load/store initiator: one access per instruction over a word-addressed req/ready bus,
// with lane steering, load extension, misalignment/illegal-funct3 rejection and a bus-wait timeout.
module lsu_bus_master #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        access_err,
  output logic        bus_fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_nx;
  logic [CW-1:0] cnt;
  logic [2:0]  f3_r;
  logic [1:0]  off_r;
  logic        done_load, fault;

  logic        access, f3_bad, misalign, legal, timeout_hit;
  logic [3:0]  be_nx;
  logic [31:0] wdata_nx, ext;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Request decode and store lane steering.
  always_comb begin
    access   = req_valid & (req_read | req_write);
    f3_bad   = req_write ? (req_funct3[2] | (req_funct3[1:0] == 2'b11))
                         : ((req_funct3[1:0] == 2'b11) | (req_funct3[2:1] == 2'b11));
    misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
               ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    legal    = !f3_bad && !misalign;
    be_nx    = 4'b1111;
    wdata_nx = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be_nx    = 4'b0001 << req_addr[1:0];
        wdata_nx = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_nx    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_nx = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
    if (!req_write) be_nx = 4'b1111;
  end

  always_comb begin
    rbyte = mem_rdata[{off_r, 3'b000} +: 8];
    rhalf = off_r[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_r)
      3'b000:  ext = {{24{rbyte[7]}}, rbyte};
      3'b001:  ext = {{16{rhalf[15]}}, rhalf};
      3'b100:  ext = {24'h0, rbyte};
      3'b101:  ext = {16'h0, rhalf};
      default: ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_nx    = state;
    stall       = 1'b0;
    timeout_hit = (cnt == LAST);
    case (state)
      IDLE: if (access && legal) begin
        stall    = 1'b1;
        state_nx = BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (mem_ready || timeout_hit) state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign mem_req    = (state == BUSY);
  assign load_valid = (state == RESP) && done_load;
  assign bus_fault  = (state == RESP) && fault;

  // Bus fields are latched at accept so they stay stable however long the responder waits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      f3_r       <= '0;
      off_r      <= '0;
      done_load  <= 1'b0;
      fault      <= 1'b0;
      access_err <= 1'b0;
      load_data  <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
    end else begin
      state      <= state_nx;
      access_err <= (state == IDLE) && access && !legal;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (access && legal) begin
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_wdata <= wdata_nx;
            mem_be    <= be_nx;
            mem_we    <= req_write;
            f3_r      <= req_funct3;
            off_r     <= req_addr[1:0];
            done_load <= 1'b0;
            fault     <= 1'b0;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            if (!mem_we) begin
              load_data <= ext;
              done_load <= 1'b1;
            end
          end else if (timeout_hit) begin
            fault     <= 1'b1;
            load_data <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
